// File: rtl/pc_unit.sv
// pc_unit: program counter with branch/jump/call/return/exception redirect and a circular return-address stack
module pc_unit #(
  parameter int WIDTH = 32,
  parameter int STEP = 1,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(32'h00000040),
  parameter int RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             exc,
  input  logic             branch,
  input  logic [WIDTH-1:0] branch_offset,
  input  logic             jump,
  input  logic             call,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             ret,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_seq,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_ovf,
  output logic             ras_unf
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);
  logic [WIDTH-1:0] stack [RAS_DEPTH];
  logic [PW-1:0] top, top_inc, top_dec;
  logic [CW-1:0] count;
  logic act, do_ret, push;
  assign pc_seq = pc + WIDTH'(STEP);
  assign ras_empty = count == '0;
  assign ras_full = count == CW'(RAS_DEPTH);
  assign top_inc = (top == PW'(RAS_DEPTH - 1)) ? '0 : top + PW'(1);
  assign top_dec = (top == '0) ? PW'(RAS_DEPTH - 1) : top - PW'(1);
  assign act = !exc && !stall;
  assign do_ret = act && ret;
  assign push = act && !ret && call;
  // entries need no reset: count alone defines which slots are live
  always_ff @(posedge clk)
    if (!reset && push) stack[top_inc] <= pc_seq;
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
      top <= '0;
      count <= '0;
      ras_ovf <= 1'b0;
      ras_unf <= 1'b0;
    end else begin
      ras_ovf <= 1'b0;
      ras_unf <= 1'b0;
      if (exc) pc <= EXC_VECTOR;
      else if (stall) pc <= pc;
      else if (do_ret) begin
        if (ras_empty) begin
          pc <= pc_seq;
          ras_unf <= 1'b1;
        end else begin
          pc <= stack[top];
          top <= top_dec;
          count <= count - CW'(1);
        end
      end else if (push) begin
        pc <= jump_target;
        top <= top_inc;
        if (ras_full) ras_ovf <= 1'b1;
        else count <= count + CW'(1);
      end else if (jump) pc <= jump_target;
      else if (branch) pc <= pc_seq + branch_offset;
      else pc <= pc_seq;
    end
  end
endmodule
